dial_input_controller: RTL and testbench
========================================

# dial_input_controller

Sequencing and filtering controller for the two 8-bit rotary dial inputs (left and right) on the Clarvi SoC. It schedules periodic sampling of both dials from a shared prescaler, debounces each with a consecutive-match filter, and accumulates wrap-aware signed rotation deltas. It raises an interrupt when either dial's filtered value changes. It sits behind the Avalon-MM interconnect and replaces direct software polling of the raw dial PIOs.

## Interface
- SAMPLE_DIV, 1000: clock cycles between sample ticks (≥2).
- STABLE_COUNT, 3: consecutive identical samples required to accept a value (1–15).
- clk  in  1  system clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- left_in  in  8  raw left dial position (asynchronous).
- right_in  in  8  raw right dial position (asynchronous).
- address  in  2  Avalon word address.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered.
- irq  out  1  level interrupt, active-high.

## Operation
- Input sync: each dial passes through a 2-flop synchronizer; the filter sees only synchronized values.
- Prescaler: counts 0..SAMPLE_DIV-1 and wraps. A one-cycle tick is asserted when the count equals SAMPLE_DIV-1. Both channels sample on the same tick.
- Per-channel filter state: cand[7:0], cnt[3:0], stable[7:0]. On each tick:
  - new_cnt = (sync == cand) ? min(cnt+1, STABLE_COUNT) : 1.
  - cand <= sync.
  - cnt <= new_cnt.
  - Commit when new_cnt == STABLE_COUNT and sync != stable:
    - stable <= sync.
    - step = (sync - stable) mod 256, interpreted as signed 8-bit (e.g. 0xFF→0x01 gives +2; 0x01→0xFF gives -2).
    - delta accumulates with saturation to [-128, +127].
    - The channel's changed flag is set.
- Register map (word addresses):
  - 0: {24'b0, left stable}, read-only.
  - 1: {24'b0, right stable}, read-only.
  - 2: {16'b0, right delta, left delta}. Reading clears both deltas. Writes are ignored.
  - 3: {29'b0, right_chg, left_chg, irq_en}.
    - irq_en is read/write.
    - Bits 1 and 2 are write-1-to-clear.
- irq = irq_en & (left_chg | right_chg), registered.
- Simultaneous events:
  - Commit in the same cycle as a delta read-clear: the delta becomes exactly that cycle's step. The read returns the pre-update value.
  - Commit in the same cycle as a W1C of that flag: the flag stays set.
  - read and write in the same cycle: the write takes effect and readdata reflects the read of pre-write state.
- Reset values:
  - stable, cand, cnt, deltas, flags, irq_en, prescaler, synchronizers: 0.
  - readdata: 0.
  - irq: 0.
- Reset mid-filter discards partial counts. The first tick after reset restarts filtering with cnt=1 if the sync value differs from cand=0.

## Timing
- Read latency is 1 cycle: readdata is valid on the cycle after read is sampled. There is no waitrequest. readdata holds its value until the next read.
- Writes take effect at the clock edge where write is sampled.
- Input to stable, worst case: 2 sync cycles, plus up to SAMPLE_DIV cycles to the first tick, plus (STABLE_COUNT-1)×SAMPLE_DIV cycles. stable, delta and flag update at the edge of the accepting tick.
- irq asserts 1 cycle after the flag sets, or 1 cycle after irq_en is written to 1 while a flag is pending. irq deasserts 1 cycle after the clearing write.
- First tick after reset is at cycle SAMPLE_DIV-1.

## Test plan
Bench parameters for all scenarios: SAMPLE_DIV=4, STABLE_COUNT=3.
- Hold left_in=0x05 from reset:
  - Left stable reads 0x05 after the third tick (cycle 11 plus 2 sync cycles).
  - delta[7:0]=0x05 and left_chg=1.
  - irq stays 0 until irq_en is written.
- Bounce left_in 0x10/0x11 alternately per tick for 6 ticks, then hold 0x11:
  - No commit occurs during bouncing.
  - Commit to 0x11 on the third held tick.
- Wrap: stable=0xFE, then hold 0x02:
  - step is +4 and delta increases by 4.
  - Then hold 0xFE: step is -4 and delta returns to its prior value.
- Saturation: 40 commits of +5 without reading delta:
  - Left delta reads 0x7F.
  - Reading register 2 again returns 0x00.
- Set irq_en=1, change right dial:
  - irq=1 one cycle after the right_chg set.
  - Write 0x4 to register 3: irq=0 one cycle later.
  - Then, with a W1C coinciding with a new commit: the flag remains 1.
- Assert reset for 1 cycle mid-filter (cnt=2):
  - All registers read 0.
  - The subsequent accept requires 3 fresh ticks.

Source files
------------

// File: rtl/dial_input_controller_if.sv
// Avalon-MM slave bundle for the dial input controller.
// The master side drives the strobes and the slave returns registered readdata.
interface dial_input_controller_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/dial_input_controller.sv
// Two-dial sampler: shared prescaler, consecutive-match debounce,
// wrap-aware saturating rotation deltas and a change interrupt.
module dial_input_controller #(
    parameter int SAMPLE_DIV   = 1000,
    parameter int STABLE_COUNT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             left_in,
    input  logic [7:0]             right_in,
    dial_input_controller_if.slave avs,
    output logic                   irq
);
    localparam int            PW   = $clog2(SAMPLE_DIV);
    localparam logic [PW-1:0] LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [3:0]    SC   = 4'(STABLE_COUNT);

    // index 0 is the left dial, index 1 the right dial
    logic [1:0][7:0] r_s1, r_s2, r_cand, r_stable, r_delta;
    logic [1:0][3:0] r_cnt;
    logic [1:0]      r_chg;
    logic            r_irq_en;
    logic            r_irq;
    logic [PW-1:0]   r_presc;
    logic [31:0]     r_rdata;

    logic            w_tick;
    logic            w_rd_clr;
    logic            w_wr_ctl;
    logic [1:0][7:0] w_in, w_step, w_base, w_dnext;
    logic [1:0][8:0] w_sum;
    logic [1:0][3:0] w_newcnt;
    logic [1:0]      w_commit;
    logic [1:0]      w_w1c;
    logic [31:0]     w_rmux;
    logic            w_unused;

    assign w_in     = {right_in, left_in};
    assign w_tick   = (r_presc == LAST);
    assign w_rd_clr = avs.read && (avs.address == 2'd2);
    assign w_wr_ctl = avs.write && (avs.address == 2'd3);
    assign w_w1c    = {avs.writedata[2], avs.writedata[1]} & {2{w_wr_ctl}};
    assign w_unused = ^avs.writedata[31:3];

    always_comb begin
        w_newcnt = '0;
        w_commit = '0;
        w_step   = '0;
        w_base   = '0;
        w_sum    = '0;
        w_dnext  = '0;
        for (int c = 0; c < 2; c++) begin
            w_newcnt[c] = 4'd1;
            if (r_s2[c] == r_cand[c])
                w_newcnt[c] = (r_cnt[c] >= SC) ? SC : r_cnt[c] + 4'd1;
            w_commit[c] = w_tick && (w_newcnt[c] == SC)
                          && (r_s2[c] != r_stable[c]);
            w_step[c] = r_s2[c] - r_stable[c];
            w_base[c] = w_rd_clr ? 8'd0 : r_delta[c];
            w_sum[c]  = {w_base[c][7], w_base[c]}
                        + {w_step[c][7], w_step[c]};
            // sign bit disagreeing with bit 8 marks an 8-bit overflow
            if (!w_commit[c])
                w_dnext[c] = w_base[c];
            else if (w_sum[c][8] != w_sum[c][7])
                w_dnext[c] = w_sum[c][8] ? 8'h80 : 8'h7F;
            else
                w_dnext[c] = w_sum[c][7:0];
        end
    end

    always_comb begin
        w_rmux = 32'd0;
        case (avs.address)
            2'd0:    w_rmux = {24'd0, r_stable[0]};
            2'd1:    w_rmux = {24'd0, r_stable[1]};
            2'd2:    w_rmux = {16'd0, r_delta[1], r_delta[0]};
            default: w_rmux = {29'd0, r_chg, r_irq_en};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_cand   <= '0;
            r_stable <= '0;
            r_delta  <= '0;
            r_cnt    <= '0;
            r_chg    <= '0;
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
            r_presc  <= '0;
            r_rdata  <= '0;
        end else begin
            r_s1    <= w_in;
            r_s2    <= r_s1;
            r_presc <= w_tick ? '0 : r_presc + ONE;
            r_delta <= w_dnext;
            r_chg   <= w_commit | (r_chg & ~w_w1c);
            r_irq   <= r_irq_en & (|r_chg);
            for (int c = 0; c < 2; c++) begin
                if (w_tick) begin
                    r_cand[c] <= r_s2[c];
                    r_cnt[c]  <= w_newcnt[c];
                end
                if (w_commit[c])
                    r_stable[c] <= r_s2[c];
            end
            if (w_wr_ctl)
                r_irq_en <= avs.writedata[0];
            if (avs.read)
                r_rdata <= w_rmux;
        end
    end

    assign avs.readdata = r_rdata;
    assign irq          = r_irq;
endmodule

// File: tb/tb_dial_input_controller.sv
// Directed bench for dial_input_controller with a read scoreboard.
// Runs with SAMPLE_DIV=4 and STABLE_COUNT=3.
module tb_dial_input_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] left_in = 8'd0;
    logic [7:0] right_in = 8'd0;
    logic       irq;
    logic [1:0] tcnt;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    dial_input_controller_if bus ();

    dial_input_controller #(
        .SAMPLE_DIV  (4),
        .STABLE_COUNT(3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .left_in (left_in),
        .right_in(right_in),
        .avs     (bus),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // reference prescaler phase: a tick edge follows tcnt==3
    always @(posedge clk) begin
        if (reset) tcnt <= 2'd0;
        else       tcnt <= (tcnt == 2'd3) ? 2'd0 : tcnt + 2'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bit was;
        do begin
            was = (tcnt == 2'd3);
            step();
        end while (!was);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e,
                      input string tag);
        exp_t x;
        bus.address = a;
        bus.read    = 1'b1;
        sb.push_back('{tag, e});
        step();
        bus.read = 1'b0;
        x = sb.pop_front();
        cmp(x.tag, bus.readdata, x.exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        step();
        bus.write = 1'b0;
    endtask

    task automatic hold_l(input logic [7:0] v);
        tick();
        left_in = v;
        repeat (3) tick();
    endtask

    initial begin
        bus.address   = 2'd0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        rd(0, 32'h0, "rst_left");
        rd(1, 32'h0, "rst_right");
        rd(2, 32'h0, "rst_delta");
        rd(3, 32'h0, "rst_ctl");
        cmp("rst_irq", 32'(irq), 32'h0);

        tick();
        left_in = 8'h05;
        tick();
        tick();
        rd(0, 32'h00, "left_two_ticks");
        tick();
        rd(0, 32'h05, "left_accept");
        rd(3, 32'h2, "left_chg");
        cmp("irq_disabled", 32'(irq), 32'h0);
        rd(2, 32'h0005, "left_delta");
        rd(2, 32'h0000, "delta_read_clear");

        wr(3, 32'h2);
        rd(3, 32'h0, "left_chg_w1c");
        tick();
        for (int i = 0; i < 6; i++) begin
            left_in = (i % 2 == 0) ? 8'h11 : 8'h10;
            tick();
        end
        left_in = 8'h11;
        tick();
        tick();
        rd(0, 32'h05, "bounce_no_commit");
        tick();
        rd(0, 32'h11, "bounce_commit");
        rd(2, 32'h000C, "bounce_delta");

        hold_l(8'hFE);
        rd(0, 32'hFE, "wrap_stable_fe");
        rd(2, 32'h00ED, "delta_neg19");
        hold_l(8'h02);
        rd(0, 32'h02, "wrap_stable_02");
        rd(2, 32'h0004, "wrap_up_plus4");
        hold_l(8'hFE);
        rd(2, 32'h00FC, "wrap_down_minus4");

        for (int k = 1; k <= 40; k++) hold_l(8'(8'hFE + 5 * k));
        rd(2, 32'h007F, "delta_saturate");
        rd(2, 32'h0000, "delta_sat_clear");
        rd(0, 32'hC6, "sat_stable");

        wr(3, 32'h6);
        rd(3, 32'h0, "flags_cleared");
        wr(3, 32'h1);
        step();
        cmp("irq_no_flag", 32'(irq), 32'h0);
        rd(3, 32'h1, "irq_en_set");
        tick();
        right_in = 8'h33;
        tick();
        tick();
        tick();
        cmp("irq_same_cycle", 32'(irq), 32'h0);
        step();
        cmp("irq_assert", 32'(irq), 32'h1);
        rd(3, 32'h5, "right_chg");
        rd(1, 32'h33, "right_stable");
        wr(3, 32'h4);
        cmp("irq_hold_edge", 32'(irq), 32'h1);
        step();
        cmp("irq_deassert", 32'(irq), 32'h0);
        rd(3, 32'h0, "ctl_after_w1c");

        wr(3, 32'h1);
        tick();
        right_in = 8'h44;
        tick();
        tick();
        while (tcnt != 2'd3) step();
        wr(3, 32'h5);
        rd(3, 32'h5, "w1c_vs_commit");
        step();
        cmp("irq_after_collide", 32'(irq), 32'h1);
        rd(2, 32'h4400, "right_delta");

        tick();
        left_in = 8'h77;
        tick();
        tick();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cmp("midrst_irq", 32'(irq), 32'h0);
        rd(0, 32'h0, "midrst_left");
        rd(1, 32'h0, "midrst_right");
        rd(2, 32'h0, "midrst_delta");
        rd(3, 32'h0, "midrst_ctl");
        tick();
        rd(0, 32'h00, "midrst_two_ticks");
        tick();
        rd(0, 32'h77, "midrst_accept");
        rd(1, 32'h44, "midrst_right_acc");
        rd(2, 32'h4477, "midrst_deltas");
        rd(3, 32'h6, "midrst_flags");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
